pacman_game_ctrl: RTL and testbench
===================================

# pacman_game_ctrl

Game-level sequencer that sits above the Pac-Man movement datapath and paces it. It runs the INI/PLAY/WIN/LOSE game state machine and generates the periodic move tick. It arbitrates the four direction buttons against the wall-sense flags (`cgDirections`) to issue at most one granted step direction per tick. It also drives `resetW` to re-home the sprite between games.

## Interface
Parameters:
- `TICK_DIV`, 10000: clock cycles per move tick; legal range 2 to 2^20−1.
- `WIN_SCORE`, 30: unsigned score threshold for a win.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: leave INI and begin play (level, sampled each cycle).
- `ack`, in, 1: acknowledge end of game; return from WIN/LOSE to INI.
- `Left`, `Up`, `Right`, `Down`, in, 1 each: raw direction buttons.
- `cgDirections`, in, 4: wall flags {left, up, right, down}; 1 = blocked.
- `score`, in, 16: current unsigned score.
- `lose`, in, 1: ghost collision (level).
- `qInit`, `qPlay`, `qWin`, `qLose`, out, 1 each: one-hot state.
- `resetW`, out, 1: sprite re-home request; equal to `qInit`.
- `moveTick`, out, 1: one-cycle step strobe.
- `moveDir`, out, 4: granted step {L,U,R,D}, one-hot or 0; valid only while `moveTick`=1, otherwise 0.
- `curDir`, out, 4: current travel direction {L,U,R,D}, one-hot or 0.

## Operation
- All outputs are registered. Reset values: `qInit`=1, `resetW`=1, all other outputs 0, internal counter 0, pending direction 0.
- INI:
  - Pending direction, `curDir` and counter are held at 0.
  - `start`=1 → PLAY.
- PLAY:
  - If `lose`=1 → LOSE. `lose` has priority over win.
  - Else if `score` ≥ `WIN_SCORE` → WIN.
  - Else stay in PLAY.
- WIN / LOSE:
  - `ack`=1 → INI. `start` is ignored.
  - `curDir` is cleared on entry.
- Button sampling (PLAY only): exactly one button high → that direction is the request this cycle and is stored as pending. Zero or more than one high → request = stored pending, which is held.
- Counter (PLAY only): increments each cycle. At `TICK_DIV`−1 it wraps to 0 and a tick decision is made. Outside PLAY the counter is held at 0.
- Tick decision uses the request and `cgDirections` sampled in that same cycle:
  1. Request nonzero and (request & `cgDirections`)=0 → `moveDir`=request, `curDir`←request, pending←0.
  2. Else `curDir` nonzero and (`curDir` & `cgDirections`)=0 → `moveDir`=`curDir`. Pending is kept.
  3. Else `moveDir`=0 and `curDir`←0 (stalled). Pending is kept. `moveTick` still pulses.
- On a cycle where PLAY exits, no tick is issued: `moveTick`=0 and `moveDir`=0 on the next cycle, even if the counter was at `TICK_DIV`−1.
- `reset` in any state, mid-tick included, restores all reset values on the next edge.

## Timing
- State transitions take effect on the edge after the input is sampled: 1-cycle latency.
- `resetW` rises together with `qInit` and stays high for the whole of INI.
- PLAY cycles are indexed from 0. The first `moveTick` is visible in PLAY cycle `TICK_DIV`. Subsequent ticks follow exactly every `TICK_DIV` cycles. `moveTick` is never high for two consecutive cycles.
- `moveDir` and the `curDir` update become visible in the same cycle as `moveTick`.
- Counter width is 20 bits. Comparisons are unsigned, with no overflow past `TICK_DIV`−1.
- A button pressed in the decision cycle is honoured in that tick; no extra latency.
- `cgDirections` is a level input sampled only in the decision cycle.

## Test plan
- Reset, then `start` for 1 cycle with `TICK_DIV`=4: `qPlay`=1 next cycle, `resetW`=0. `moveTick` pulses in PLAY cycles 4, 8, 12 with `moveDir`=0.
- `Right` pulsed for 1 cycle, `cgDirections`=0000: the next tick gives `moveDir`=0010 and `curDir`=0010. Later ticks with no buttons repeat 0010.
- `curDir`=0010, `Up` pressed, `cgDirections`=0100 (up blocked): tick gives `moveDir`=0010 with pending kept. Once `cgDirections`=0000, the next tick gives `moveDir`=0100 and `curDir`=0100.
- `Left`+`Up` high together with nothing pending: the pending direction is unchanged. With `curDir` blocked (`cgDirections`=1111), tick gives `moveDir`=0000 and `curDir`=0000.
- `score`=30 and `lose`=1 in the same cycle while the counter is at `TICK_DIV`−1: next cycle `qLose`=1, `moveTick`=0, `curDir`=0. `ack` → `qInit`=1 and `resetW`=1.
- `reset` asserted in the decision cycle: next cycle `qInit`=1, `moveTick`=0, and a later `start` gives the first tick again at PLAY cycle `TICK_DIV`.

Source files
------------

// File: rtl/pacman_game_ctrl.sv
// Pac-Man game sequencer: INI/PLAY/WIN/LOSE state machine, move-tick pacing
// and button/wall arbitration producing one granted step direction per tick.
module pacman_game_ctrl #(
    parameter int TICK_DIV  = 10000,
    parameter int WIN_SCORE = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ack,
    input  logic        Left,
    input  logic        Up,
    input  logic        Right,
    input  logic        Down,
    input  logic [3:0]  cgDirections,
    input  logic [15:0] score,
    input  logic        lose,
    output logic        qInit,
    output logic        qPlay,
    output logic        qWin,
    output logic        qLose,
    output logic        resetW,
    output logic        moveTick,
    output logic [3:0]  moveDir,
    output logic [3:0]  curDir
);

    // One-hot encoding lets the state flops drive the q* outputs directly.
    typedef enum logic [3:0] {
        S_INI  = 4'b0001,
        S_PLAY = 4'b0010,
        S_WIN  = 4'b0100,
        S_LOSE = 4'b1000
    } state_t;

    localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
    localparam logic [15:0] WIN_THR   = 16'(WIN_SCORE);

    state_t      state;
    logic [19:0] cnt;
    logic [3:0]  pending;
    logic [3:0]  btn;
    logic        btn_one;
    logic [3:0]  req;

    assign btn     = {Left, Up, Right, Down};
    assign btn_one = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    // A lone button both requests and is remembered; otherwise fall back to memory.
    assign req     = btn_one ? btn : pending;

    assign qInit  = state[0];
    assign qPlay  = state[1];
    assign qWin   = state[2];
    assign qLose  = state[3];
    assign resetW = state[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_INI;
            cnt      <= 20'd0;
            pending  <= 4'd0;
            curDir   <= 4'd0;
            moveTick <= 1'b0;
            moveDir  <= 4'd0;
        end else begin
            moveTick <= 1'b0;
            moveDir  <= 4'd0;
            case (state)
                S_INI: begin
                    cnt     <= 20'd0;
                    pending <= 4'd0;
                    curDir  <= 4'd0;
                    if (start) state <= S_PLAY;
                end
                S_PLAY: begin
                    if (lose || score >= WIN_THR) begin
                        // Leaving PLAY suppresses any tick due this cycle.
                        state   <= lose ? S_LOSE : S_WIN;
                        cnt     <= 20'd0;
                        pending <= 4'd0;
                        curDir  <= 4'd0;
                    end else begin
                        pending <= req;
                        if (cnt == TICK_LAST) begin
                            cnt      <= 20'd0;
                            moveTick <= 1'b1;
                            if (req != 4'd0 && (req & cgDirections) == 4'd0) begin
                                moveDir <= req;
                                curDir  <= req;
                                pending <= 4'd0;
                            end else if (curDir != 4'd0 && (curDir & cgDirections) == 4'd0) begin
                                moveDir <= curDir;
                            end else begin
                                curDir <= 4'd0;
                            end
                        end else begin
                            cnt <= cnt + 20'd1;
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    cnt     <= 20'd0;
                    pending <= 4'd0;
                    curDir  <= 4'd0;
                    if (ack) state <= S_INI;
                end
                default: state <= S_INI;
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Directed bench for pacman_game_ctrl with TICK_DIV=4; observes all outputs
// as one vector {qInit,qPlay,qWin,qLose,resetW,moveTick,moveDir,curDir}.
module tb_pacman_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        Left = 1'b0, Up = 1'b0, Right = 1'b0, Down = 1'b0;
    logic [3:0]  cgDirections = 4'd0;
    logic [15:0] score = 16'd0;
    logic        lose = 1'b0;
    logic        qInit, qPlay, qWin, qLose, resetW, moveTick;
    logic [3:0]  moveDir, curDir;
    logic [13:0] obs;
    logic [13:0] exp_v;
    int          total = 0;
    int          bad = 0;

    pacman_game_ctrl #(.TICK_DIV(4), .WIN_SCORE(30)) dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack),
        .Left(Left), .Up(Up), .Right(Right), .Down(Down),
        .cgDirections(cgDirections), .score(score), .lose(lose),
        .qInit(qInit), .qPlay(qPlay), .qWin(qWin), .qLose(qLose),
        .resetW(resetW), .moveTick(moveTick), .moveDir(moveDir), .curDir(curDir)
    );

    always #5 clk = ~clk;

    assign obs = {qInit, qPlay, qWin, qLose, resetW, moveTick, moveDir, curDir};

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        total++;
        if (obs !== 14'b1000_1_0_0000_0000) begin
            $display("FAIL reset got=%b exp=%b", obs, 14'b1000_1_0_0000_0000); bad++;
        end
        step(1);
        total++;
        if (obs !== 14'b1000_1_0_0000_0000) begin
            $display("FAIL ini_hold got=%b exp=%b", obs, 14'b1000_1_0_0000_0000); bad++;
        end
    endtask

    // PLAY cycles 0..12; ticks at 4, 8, 12 with no direction.
    task automatic test_idle_ticks();
        start = 1'b1;
        step(1);
        start = 1'b0;
        total++;
        if (obs !== 14'b0100_0_0_0000_0000) begin
            $display("FAIL play_entry got=%b exp=%b", obs, 14'b0100_0_0_0000_0000); bad++;
        end
        for (int c = 1; c <= 12; c++) begin
            step(1);
            exp_v = {4'b0100, 1'b0, 1'((c % 4) == 0), 4'b0000, 4'b0000};
            total++;
            if (obs !== exp_v) begin
                $display("FAIL idle_tick c=%0d got=%b exp=%b", c, obs, exp_v); bad++;
            end
        end
    endtask

    // From PLAY cycle 12: Right pulse, ticks at 16 and 20 move right.
    task automatic test_right();
        Right = 1'b1;
        step(1);
        Right = 1'b0;
        step(3);
        total++;
        if (obs !== 14'b0100_0_1_0010_0010) begin
            $display("FAIL right_tick got=%b exp=%b", obs, 14'b0100_0_1_0010_0010); bad++;
        end
        step(1);
        total++;
        if (obs !== 14'b0100_0_0_0000_0010) begin
            $display("FAIL right_between got=%b exp=%b", obs, 14'b0100_0_0_0000_0010); bad++;
        end
        step(3);
        total++;
        if (obs !== 14'b0100_0_1_0010_0010) begin
            $display("FAIL right_repeat got=%b exp=%b", obs, 14'b0100_0_1_0010_0010); bad++;
        end
    endtask

    // From cycle 20: Up requested while up is walled; keep going right, then turn.
    task automatic test_blocked_up();
        step(1);
        Up = 1'b1;
        cgDirections = 4'b0100;
        step(1);
        Up = 1'b0;
        step(2);
        total++;
        if (obs !== 14'b0100_0_1_0010_0010) begin
            $display("FAIL up_blocked got=%b exp=%b", obs, 14'b0100_0_1_0010_0010); bad++;
        end
        cgDirections = 4'b0000;
        step(4);
        total++;
        if (obs !== 14'b0100_0_1_0100_0100) begin
            $display("FAIL up_turn got=%b exp=%b", obs, 14'b0100_0_1_0100_0100); bad++;
        end
    endtask

    // From cycle 28: two buttons at once do not set pending; all walls stall.
    task automatic test_multi_button();
        Left = 1'b1;
        Up = 1'b1;
        cgDirections = 4'b1111;
        step(4);
        total++;
        if (obs !== 14'b0100_0_1_0000_0000) begin
            $display("FAIL stall got=%b exp=%b", obs, 14'b0100_0_1_0000_0000); bad++;
        end
        Left = 1'b0;
        Up = 1'b0;
        cgDirections = 4'b0000;
        step(4);
        total++;
        if (obs !== 14'b0100_0_1_0000_0000) begin
            $display("FAIL multi_no_pending got=%b exp=%b", obs, 14'b0100_0_1_0000_0000); bad++;
        end
    endtask

    // From cycle 36: move down, then lose+score together in the decision cycle.
    task automatic test_lose_priority();
        Down = 1'b1;
        step(1);
        Down = 1'b0;
        step(3);
        total++;
        if (obs !== 14'b0100_0_1_0001_0001) begin
            $display("FAIL down_tick got=%b exp=%b", obs, 14'b0100_0_1_0001_0001); bad++;
        end
        step(3);
        score = 16'd30;
        lose = 1'b1;
        step(1);
        lose = 1'b0;
        score = 16'd0;
        total++;
        if (obs !== 14'b0001_0_0_0000_0000) begin
            $display("FAIL lose_entry got=%b exp=%b", obs, 14'b0001_0_0_0000_0000); bad++;
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        total++;
        if (obs !== 14'b0001_0_0_0000_0000) begin
            $display("FAIL lose_ignores_start got=%b exp=%b", obs, 14'b0001_0_0_0000_0000); bad++;
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        total++;
        if (obs !== 14'b1000_1_0_0000_0000) begin
            $display("FAIL lose_ack got=%b exp=%b", obs, 14'b1000_1_0_0000_0000); bad++;
        end
    endtask

    task automatic test_win();
        start = 1'b1;
        step(1);
        start = 1'b0;
        score = 16'd29;
        step(1);
        total++;
        if (obs !== 14'b0100_0_0_0000_0000) begin
            $display("FAIL score29_stays got=%b exp=%b", obs, 14'b0100_0_0_0000_0000); bad++;
        end
        score = 16'd30;
        step(1);
        score = 16'd0;
        total++;
        if (obs !== 14'b0010_0_0_0000_0000) begin
            $display("FAIL win_entry got=%b exp=%b", obs, 14'b0010_0_0_0000_0000); bad++;
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        total++;
        if (obs !== 14'b1000_1_0_0000_0000) begin
            $display("FAIL win_ack got=%b exp=%b", obs, 14'b1000_1_0_0000_0000); bad++;
        end
    endtask

    // Reset in the decision cycle, then a fresh game ticks first at cycle 4.
    task automatic test_reset_mid_tick();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        Right = 1'b1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        Right = 1'b0;
        total++;
        if (obs !== 14'b1000_1_0_0000_0000) begin
            $display("FAIL reset_mid got=%b exp=%b", obs, 14'b1000_1_0_0000_0000); bad++;
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            exp_v = {4'b0100, 1'b0, 1'(c == 4), 4'b0000, 4'b0000};
            total++;
            if (obs !== exp_v) begin
                $display("FAIL restart_tick c=%0d got=%b exp=%b", c, obs, exp_v); bad++;
            end
        end
    endtask

    initial begin
        step(1);
        test_reset();
        test_idle_ticks();
        test_right();
        test_blocked_up();
        test_multi_button();
        test_lose_priority();
        test_win();
        test_reset_mid_tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
